// File: rtl/voice.sv
// Single SID-style voice: 24-bit phase accumulator, four waveforms,
// 8-bit ADSR envelope and an amplitude-modulated 12-bit output.
module voice #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  control,
    input  logic [11:0] pw,
    input  logic [15:0] adsr,
    input  logic [15:0] freq,
    output logic [11:0] dataOut
);

    typedef enum logic [1:0] {
        ATTACK  = 2'b00,
        DECAY   = 2'b01,
        SUSTAIN = 2'b10,
        RELEASE = 2'b11
    } env_state_t;

    localparam int          DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [22:0] SEED = 23'h7FFFF8;

    logic [DW-1:0] div;
    logic          tick;

    logic [23:0] acc, acc_n;
    logic [22:0] lfsr, lfsr_n;

    env_state_t  state, state_n;
    logic [7:0]  env, env_n;
    logic [14:0] rate_cnt, rate_n;
    logic [4:0]  exp_cnt, exp_n;
    logic        gate_q;

    logic        gate, rise, fall, test;
    logic [3:0]  nib;
    logic [14:0] period;
    logic        step;
    logic [4:0]  exp_per, exp_inc;
    logic        exp_hit;
    logic [7:0]  sus_lvl;

    logic [11:0] tri_w, saw_w, pul_w, noi_w, wave;
    logic [19:0] prod;

    // sync and ring-mod are not modelled in a standalone voice
    logic unused_bits;
    assign unused_bits = ^control[2:1];

    function automatic logic [14:0] rate_period(input logic [3:0] n);
        logic [14:0] p;
        case (n)
            4'd0:    p = 15'd9;
            4'd1:    p = 15'd32;
            4'd2:    p = 15'd63;
            4'd3:    p = 15'd95;
            4'd4:    p = 15'd149;
            4'd5:    p = 15'd220;
            4'd6:    p = 15'd267;
            4'd7:    p = 15'd313;
            4'd8:    p = 15'd392;
            4'd9:    p = 15'd977;
            4'd10:   p = 15'd1954;
            4'd11:   p = 15'd3126;
            4'd12:   p = 15'd3907;
            4'd13:   p = 15'd11720;
            4'd14:   p = 15'd19532;
            default: p = 15'd31251;
        endcase
        return p;
    endfunction

    // approximates an exponential decay by stretching the step spacing
    function automatic logic [4:0] exp_period(input logic [7:0] e);
        logic [4:0] p;
        if (e > 8'd93)       p = 5'd1;
        else if (e >= 8'd55) p = 5'd2;
        else if (e >= 8'd27) p = 5'd4;
        else if (e >= 8'd15) p = 5'd8;
        else if (e >= 8'd7)  p = 5'd16;
        else                 p = 5'd30;
        return p;
    endfunction

    assign tick    = (div == DW'(CLK_DIV - 1));
    assign gate    = control[0];
    assign test    = control[3];
    assign rise    = gate & ~gate_q;
    assign fall    = ~gate & gate_q;
    assign sus_lvl = {adsr[7:4], adsr[7:4]};

    // divides clk down to the synthesis tick
    always_ff @(posedge clk) begin
        if (rst) div <= '0;
        else     div <= tick ? '0 : div + 1'b1;
    end

    // oscillator and noise LFSR next values
    always_comb begin
        acc_n  = test ? 24'd0 : acc + {8'd0, freq};
        lfsr_n = lfsr;
        if (test)
            lfsr_n = SEED;
        else if (!acc[19] && acc_n[19])
            lfsr_n = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
    end

    // oscillator state advances on ticks only
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            lfsr <= SEED;
        end else if (tick) begin
            acc  <= acc_n;
            lfsr <= lfsr_n;
        end
    end

    // rate selection for the active envelope phase
    always_comb begin
        case (state)
            ATTACK:  nib = adsr[15:12];
            RELEASE: nib = adsr[3:0];
            default: nib = adsr[11:8];
        endcase
    end

    assign period  = rate_period(nib);
    assign step    = (rate_cnt == period - 15'd1);
    assign exp_per = exp_period(env);
    assign exp_inc = exp_cnt + 5'd1;
    assign exp_hit = (exp_inc >= exp_per);

    // envelope next-state and level; both counters restart on a phase change
    always_comb begin
        state_n = state;
        env_n   = env;
        rate_n  = step ? 15'd0 : rate_cnt + 15'd1;
        exp_n   = exp_cnt;
        if (rise) begin
            state_n = ATTACK;
            rate_n  = '0;
            exp_n   = '0;
        end else if (fall) begin
            state_n = RELEASE;
            rate_n  = '0;
            exp_n   = '0;
        end else begin
            case (state)
                ATTACK: begin
                    if (env == 8'hFF) begin
                        state_n = DECAY;
                        rate_n  = '0;
                        exp_n   = '0;
                    end else if (step) begin
                        env_n = env + 8'd1;
                        if (env == 8'hFE) begin
                            state_n = DECAY;
                            rate_n  = '0;
                            exp_n   = '0;
                        end
                    end
                end
                DECAY: begin
                    if (env <= sus_lvl) begin
                        state_n = SUSTAIN;
                        env_n   = sus_lvl;
                        rate_n  = '0;
                        exp_n   = '0;
                    end else if (step) begin
                        if (exp_hit) begin
                            env_n = env - 8'd1;
                            exp_n = '0;
                        end else begin
                            exp_n = exp_inc;
                        end
                    end
                end
                SUSTAIN: begin
                    rate_n = '0;
                    exp_n  = '0;
                end
                default: begin
                    if (step && env != 8'd0) begin
                        if (exp_hit) begin
                            env_n = env - 8'd1;
                            exp_n = '0;
                        end else begin
                            exp_n = exp_inc;
                        end
                    end
                end
            endcase
        end
    end

    // envelope state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RELEASE;
            env      <= '0;
            rate_cnt <= '0;
            exp_cnt  <= '0;
            gate_q   <= 1'b0;
        end else if (tick) begin
            state    <= state_n;
            env      <= env_n;
            rate_cnt <= rate_n;
            exp_cnt  <= exp_n;
            gate_q   <= gate;
        end
    end

    // waveform generators combined by AND
    always_comb begin
        saw_w = acc[23:12];
        tri_w = acc[23] ? ~acc[22:11] : acc[22:11];
        pul_w = (acc[23:12] >= pw) ? 12'hFFF : 12'h000;
        noi_w = {lfsr[20], lfsr[18], lfsr[14], lfsr[11],
                 lfsr[9], lfsr[5], lfsr[2], lfsr[0], 4'b0000};
        wave  = 12'hFFF;
        if (control[4]) wave = wave & tri_w;
        if (control[5]) wave = wave & saw_w;
        if (control[6]) wave = wave & pul_w;
        if (control[7]) wave = wave & noi_w;
        if (control[7:4] == 4'd0) wave = 12'h000;
    end

    assign prod = {8'd0, wave} * {12'd0, env};

    // amplitude-modulated output register
    always_ff @(posedge clk) begin
        if (rst) dataOut <= '0;
        else     dataOut <= prod[19:8];
    end

endmodule

// File: tb/tb_voice.sv
// Scoreboard bench for voice: a cycle model predicts dataOut,
// plus directed checks on envelope timing and waveforms.
module tb_voice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  control = '0;
    logic [11:0] pw = '0;
    logic [15:0] adsr = '0;
    logic [15:0] freq = '0;
    logic [11:0] dataOut;

    voice #(.CLK_DIV(1)) dut (
        .clk(clk),
        .rst(rst),
        .control(control),
        .pw(pw),
        .adsr(adsr),
        .freq(freq),
        .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [11:0] sb_q[$];

    int rates[16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                      392, 977, 1954, 3126, 3907, 11720, 19532, 31251};

    logic [23:0] m_acc;
    logic [22:0] m_lfsr;
    logic [7:0]  m_env;
    logic [1:0]  m_st;
    int          m_rc, m_ec;
    bit          m_gq;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_tbl(input logic [7:0] e);
        if (e > 93) return 1;
        if (e >= 55) return 2;
        if (e >= 27) return 4;
        if (e >= 15) return 8;
        if (e >= 7) return 16;
        return 30;
    endfunction

    function automatic logic [11:0] m_wave(input logic [23:0] a,
                                           input logic [22:0] l,
                                           input logic [7:0] c,
                                           input logic [11:0] p);
        logic [11:0] w, t;
        if (c[7:4] == 4'd0) return 12'h000;
        w = 12'hFFF;
        t = a[23] ? ~a[22:11] : a[22:11];
        if (c[4]) w &= t;
        if (c[5]) w &= a[23:12];
        if (c[6]) w &= (a[23:12] >= p) ? 12'hFFF : 12'h000;
        if (c[7]) w &= {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0], 4'b0};
        return w;
    endfunction

    task automatic m_edge();
        logic [19:0] pr;
        logic [23:0] na;
        logic [7:0]  ss, ne;
        logic [1:0]  ns;
        int per, nrc, nec;
        bit step, g, rise, fall, dec;
        pr = {8'd0, m_wave(m_acc, m_lfsr, control, pw)} * {12'd0, m_env};
        sb_q.push_back(rst ? 12'h000 : pr[19:8]);
        if (rst) begin
            m_acc = 0; m_lfsr = 23'h7FFFF8; m_env = 0; m_st = 2'b11;
            m_rc = 0; m_ec = 0; m_gq = 0;
            return;
        end
        g = control[0];
        rise = g && !m_gq;
        fall = !g && m_gq;
        m_gq = g;
        na = control[3] ? 24'd0 : m_acc + {8'd0, freq};
        if (control[3]) m_lfsr = 23'h7FFFF8;
        else if (!m_acc[19] && na[19])
            m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
        case (m_st)
            2'b00: per = rates[adsr[15:12]];
            2'b11: per = rates[adsr[3:0]];
            default: per = rates[adsr[11:8]];
        endcase
        step = (m_rc == per - 1);
        nrc = step ? 0 : m_rc + 1;
        nec = m_ec;
        ne = m_env;
        ns = m_st;
        ss = {adsr[7:4], adsr[7:4]};
        dec = 0;
        if (rise) ns = 2'b00;
        else if (fall) ns = 2'b11;
        else if (m_st == 2'b00) begin
            if (m_env == 8'hFF) ns = 2'b01;
            else if (step) begin
                ne = m_env + 1;
                if (ne == 8'hFF) ns = 2'b01;
            end
        end else if (m_st == 2'b01) begin
            if (m_env <= ss) begin ns = 2'b10; ne = ss; end
            else if (step) dec = 1;
        end else if (m_st == 2'b10) begin
            nrc = 0;
        end else if (step && m_env != 0) dec = 1;
        if (dec) begin
            if (m_ec + 1 >= exp_tbl(m_env)) begin ne = m_env - 1; nec = 0; end
            else nec = m_ec + 1;
        end
        if (ns != m_st || rise || fall || m_st == 2'b10) begin
            if (ns != m_st || rise || fall) nrc = 0;
            nec = 0;
        end
        m_acc = na; m_env = ne; m_st = ns; m_rc = nrc; m_ec = nec;
    endtask

    task automatic cyc();
        logic [11:0] e;
        m_edge();
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("dout", {20'd0, dataOut}, {20'd0, e});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n, cnt;
        logic [11:0] prev;
        bit done;

        @(negedge clk);
        rst = 1; control = 8'hFF; pw = 12'h123; adsr = 16'hFFFF; freq = 16'hFFFF;
        run(2);
        chk("rst_dout", {20'd0, dataOut}, 32'd0);
        chk("rst_state", {30'd0, dut.state}, 32'd3);
        chk("rst_env", {24'd0, dut.env}, 32'd0);
        rst = 0; control = 8'h00; pw = 0; adsr = 16'h0070; freq = 0;
        run(20);
        chk("idle_dout", {20'd0, dataOut}, 32'd0);

        control = 8'h11;
        cyc();
        n = 0; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cyc(); n++;
            if (dut.env == 8'hFF) done = 1;
        end
        chk("attack_ticks", n, 2295);
        chk("attack_decay", {30'd0, dut.state}, 32'd1);
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cyc();
            if (dut.state == 2'b10) done = 1;
        end
        chk("sustain_reached", {31'd0, done}, 32'd1);
        chk("sustain_lvl", {24'd0, dut.env}, 32'h77);

        freq = 16'h1000; adsr = 16'h00F0; control = 8'h20;
        cyc();
        control = 8'h21;
        run(3);
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            cyc();
            if (dut.state == 2'b10) done = 1;
        end
        chk("saw_sustain", {31'd0, done}, 32'd1);
        chk("saw_env", {24'd0, dut.env}, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            prev = dut.wave;
            cyc();
            chk("saw_step", {20'd0, dut.wave - prev}, 32'd1);
        end

        control = 8'h41; pw = 12'h800;
        run(2);
        cnt = 0;
        for (int i = 0; i < 4096; i++) begin
            cyc();
            if (dut.wave == 12'hFFF) cnt++;
        end
        chk("pulse_duty", cnt, 2048);
        pw = 12'h000;
        run(3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pulse_full", {20'd0, dataOut}, 32'hFEF);
        end

        control = 8'h11; adsr = 16'h0070; freq = 16'd4389;
        run(4);
        chk("sus_hold_env", {24'd0, dut.env}, 32'hFF);
        chk("sus_hold_st", {30'd0, dut.state}, 32'd2);
        control = 8'h10;
        done = 0;
        for (int i = 0; i < 12000 && !done; i++) begin
            cyc();
            if (dut.env == 8'h00) done = 1;
        end
        chk("release_done", {31'd0, done}, 32'd1);
        chk("release_st", {30'd0, dut.state}, 32'd3);
        run(20);
        chk("release_floor", {24'd0, dut.env}, 32'd0);

        control = 8'h89;
        run(10);
        chk("test_acc", {8'd0, dut.acc}, 32'd0);
        chk("noise_seed", {20'd0, dut.wave}, 32'hFC0);
        control = 8'h81; freq = 16'hFFFF;
        run(300);
        chk("noise_lfsr", {9'd0, dut.lfsr}, {9'd0, m_lfsr});
        control = 8'h31; freq = 16'h0123;
        run(50);
        chk("tri_and_saw", {20'd0, dut.wave},
            {20'd0, m_wave(m_acc, m_lfsr, control, pw)});

        rst = 1;
        cyc();
        chk("midrst_env", {24'd0, dut.env}, 32'd0);
        chk("midrst_state", {30'd0, dut.state}, 32'd3);
        chk("midrst_acc", {8'd0, dut.acc}, 32'd0);
        chk("midrst_dout", {20'd0, dataOut}, 32'd0);
        rst = 0; control = 8'h00;
        run(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
